uart_rx: RTL and testbench

//   Receives 8N1 UART frames on the usb_rx pin, the host-to-FPGA direction
//   of the USB-serial bridge whose usb_tx side the top level already drives.

---
 rtl/uart_rx.sv | 138 +++++++++++++
 tb/tb_uart_rx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver for the host-to-FPGA direction of the USB-serial
// bridge. Synchronises the asynchronous line and samples each bit near its
// centre. Bits are deserialised LSB first. Each good byte is presented with a
// one-cycle strobe, and a low stop bit is reported with a one-cycle error strobe.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state, state_next;
  logic             rx_meta, rx_s;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       idx, idx_next;
  logic [7:0]       shift, shift_next;
  logic [7:0]       data_next;
  logic             valid_next, ferr_next;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: bit timing, mid-bit sampling and strobe generation.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    shift_next = shift;
    data_next  = rx_data;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (!rx_s) state_next = START;
      end
      START: begin
        // Half a bit after the falling edge: still low means a real start bit.
        if (cnt == HALF_LAST) begin
          cnt_next   = '0;
          idx_next   = '0;
          state_next = rx_s ? IDLE : DATA;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_next        = '0;
          shift_next[idx] = rx_s;
          if (idx == 3'd7) state_next = STOP;
          else             idx_next   = idx + 3'd1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            data_next  = shift;
            valid_next = 1'b1;
            state_next = IDLE;
          end else begin
            // Stop bit low: drop the byte and wait out a break / stuck line.
            ferr_next  = 1'b1;
            state_next = WAIT_IDLE;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control and output registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= '0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      idx       <= idx_next;
      rx_data   <= data_next;
      rx_valid  <= valid_next;
      frame_err <= ferr_next;
    end
  end

  // Deserialiser shift register; contents only matter once a frame completes.
  always_ff @(posedge clk) begin
    shift <= shift_next;
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx. The reference model
// is the serial line itself: every byte sent with a good stop bit is expected
// back in order, and a bad stop bit yields one error strobe and no byte.
`timescale 1ns/1ps
module tb_uart_rx;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, ferr_a, ferr_b, busy_a, busy_b;

  int errors = 0;
  int checks = 0;

  byte_q_t got_a, got_b;
  byte_q_t exp_a, exp_b;
  int      ferr_cnt_a = 0;
  int      ferr_cnt_b = 0;
  int      both_cnt = 0;
  int      dbl_cnt = 0;
  logic    prev_va = 1'b0, prev_fa = 1'b0, prev_vb = 1'b0, prev_fb = 1'b0;
  logic [7:0] last_a;

  uart_rx #(.CLKS_PER_BIT(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .rx_data(data_a),
    .rx_valid(valid_a), .frame_err(ferr_a), .busy(busy_a)
  );

  uart_rx #(.CLKS_PER_BIT(868)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b), .rx_data(data_b),
    .rx_valid(valid_b), .frame_err(ferr_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  // Collect strobes away from the active edge.
  always @(negedge clk) begin
    if (valid_a) got_a.push_back(data_a);
    if (valid_b) got_b.push_back(data_b);
    if (ferr_a) ferr_cnt_a <= ferr_cnt_a + 1;
    if (ferr_b) ferr_cnt_b <= ferr_cnt_b + 1;
    if ((valid_a && ferr_a) || (valid_b && ferr_b)) both_cnt <= both_cnt + 1;
    if ((valid_a && prev_va) || (ferr_a && prev_fa) ||
        (valid_b && prev_vb) || (ferr_b && prev_fb)) dbl_cnt <= dbl_cnt + 1;
    prev_va <= valid_a;
    prev_fa <= ferr_a;
    prev_vb <= valid_b;
    prev_fb <= ferr_b;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qget(input byte_q_t q, input int i);
    return (i < q.size()) ? {24'h0, q[i]} : 32'hDEAD;
  endfunction

  task automatic drive(input bit which, input logic v);
    if (which) rx_b = v;
    else       rx_a = v;
  endtask

  // One 8N1 frame; the line is left at the stop-bit level afterwards.
  task automatic send_frame(input bit which, input logic [7:0] b, input logic stop,
                            input real bit_ns);
    drive(which, 1'b0);
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      drive(which, b[i]);
      #(bit_ns);
    end
    drive(which, stop);
    #(bit_ns);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int f0;
    int v0;
    int seen;
    int zero_at;

    // Reset state
    repeat (5) @(posedge clk);
    #1;
    check("rst_data", data_a, 8'h00);
    check("rst_valid", valid_a, 0);
    check("rst_ferr", ferr_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_busy_b", busy_b, 0);
    rst_n = 1'b1;
    last_a = 8'h00;
    #320;

    // 8'hA5 with latency measurement from the start edge
    got_a.delete();
    f0 = ferr_cnt_a;
    @(posedge clk);
    #1;
    lat = 0;
    fork
      send_frame(0, 8'hA5, 1'b1, 160.0);
      begin
        for (int i = 1; i <= 200; i++) begin
          @(posedge clk);
          #1;
          if (valid_a) begin
            lat = i;
            break;
          end
        end
      end
    join
    #100;
    last_a = 8'hA5;
    check("a5_latency_in_154_156", (lat >= 154 && lat <= 156), 1);
    check("a5_count", got_a.size(), 1);
    check("a5_byte", qget(got_a, 0), 8'hA5);
    check("a5_data", data_a, last_a);
    check("a5_no_ferr", ferr_cnt_a - f0, 0);

    // Back-to-back 8'h00 then 8'hFF, no idle gap
    got_a.delete();
    send_frame(0, 8'h00, 1'b1, 160.0);
    send_frame(0, 8'hFF, 1'b1, 160.0);
    #100;
    last_a = 8'hFF;
    check("b2b_count", got_a.size(), 2);
    check("b2b_first", qget(got_a, 0), 8'h00);
    check("b2b_second", qget(got_a, 1), 8'hFF);
    check("b2b_data", data_a, last_a);
    #320;

    // 4-clock glitch on an idle line
    got_a.delete();
    f0 = ferr_cnt_a;
    @(posedge clk);
    #1;
    seen = 0;
    zero_at = -1;
    fork
      begin
        rx_a = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_a = 1'b1;
      end
      begin
        for (int i = 1; i <= 20; i++) begin
          @(posedge clk);
          #1;
          if (busy_a) seen = 1;
          else if (seen != 0 && zero_at < 0) zero_at = i;
        end
      end
    join
    check("glitch_busy_seen", seen, 1);
    check("glitch_busy_clear_by_12", (zero_at > 0 && zero_at <= 12), 1);
    check("glitch_no_valid", got_a.size(), 0);
    check("glitch_no_ferr", ferr_cnt_a - f0, 0);
    #320;

    // 8'h3C with low stop bit, line held low 40 bit times
    got_a.delete();
    f0 = ferr_cnt_a;
    send_frame(0, 8'h3C, 1'b0, 160.0);
    #(40 * 160.0);
    check("break_busy_held", busy_a, 1);
    drive(0, 1'b1);
    #(3 * 160.0);
    check("break_one_ferr", ferr_cnt_a - f0, 1);
    check("break_no_valid", got_a.size(), 0);
    check("break_data_kept", data_a, last_a);
    check("break_idle_again", busy_a, 0);
    send_frame(0, 8'h5A, 1'b1, 160.0);
    #100;
    last_a = 8'h5A;
    check("after_break_count", got_a.size(), 1);
    check("after_break_byte", qget(got_a, 0), 8'h5A);
    check("after_break_data", data_a, last_a);
    #320;

    // Reset during bit 4 of 8'hC3
    got_a.delete();
    f0 = ferr_cnt_a;
    fork
      send_frame(0, 8'hC3, 1'b1, 160.0);
      begin
        #(5.5 * 160.0);
        rst_n = 1'b0;
        #1;
        check("midrst_data", data_a, 8'h00);
        check("midrst_valid", valid_a, 0);
        check("midrst_ferr", ferr_cnt_a - f0 + ferr_a, 0);
        check("midrst_busy", busy_a, 0);
      end
    join
    #200;
    rst_n = 1'b1;
    last_a = 8'h00;
    #320;
    check("midrst_no_strobe", got_a.size(), 0);
    send_frame(0, 8'h81, 1'b1, 160.0);
    #100;
    last_a = 8'h81;
    check("after_rst_count", got_a.size(), 1);
    check("after_rst_byte", qget(got_a, 0), 8'h81);
    check("after_rst_data", data_a, last_a);
    #320;

    // Random bytes with +/-2% baud skew on both receivers in parallel
    got_a.delete();
    got_b.delete();
    exp_a.delete();
    exp_b.delete();
    f0 = ferr_cnt_a;
    v0 = ferr_cnt_b;
    fork
      begin
        for (int n = 0; n < 200; n++) begin
          logic [7:0] b;
          real bn;
          b  = 8'($urandom);
          bn = 160.0 * (1.0 + (real'($urandom_range(0, 400)) - 200.0) / 10000.0);
          send_frame(0, b, 1'b1, bn);
          exp_a.push_back(b);
          #(real'($urandom_range(0, 3)) * bn);
        end
      end
      begin
        for (int n = 0; n < 6; n++) begin
          logic [7:0] b;
          real bn;
          b  = 8'($urandom);
          bn = 8680.0 * (1.0 + (real'($urandom_range(0, 400)) - 200.0) / 10000.0);
          send_frame(1, b, 1'b1, bn);
          exp_b.push_back(b);
          #(real'($urandom_range(0, 1)) * bn);
        end
      end
    join
    #1000;
    check("rnd16_count", got_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size(); i++) check("rnd16_byte", qget(got_a, i), exp_a[i]);
    check("rnd16_no_ferr", ferr_cnt_a - f0, 0);
    check("rnd868_count", got_b.size(), exp_b.size());
    for (int i = 0; i < exp_b.size(); i++) check("rnd868_byte", qget(got_b, i), exp_b[i]);
    check("rnd868_no_ferr", ferr_cnt_b - v0, 0);
    if (exp_a.size() > 0) check("rnd16_last_data", data_a, exp_a[exp_a.size() - 1]);

    // Strobe properties over the whole run
    check("never_valid_and_ferr", both_cnt, 0);
    check("strobes_one_cycle", dbl_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
